// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Contents:
//   state_e       - loader FSM states
//   DEPTH_DEFAULT - default instruction-memory capacity in 32-bit words
//   HDR_W         - width of the big-endian word-count header
//   CSUM_W        - width of the XOR checksum byte
//   count_ok()    - header range check (1 <= N <= depth)
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    RUN,
    ERROR
  } state_e;

  localparam int DEPTH_DEFAULT = 256;
  localparam int HDR_W         = 16;
  localparam int CSUM_W        = 8;

  // A zero-length image or one larger than the memory is rejected at the
  // header. This bound is also what keeps the word index from wrapping.
  function automatic logic count_ok(input logic [HDR_W-1:0] n, input int depth);
    return (n != '0) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a stream of bytes, most significant byte first, into 32-bit words.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   byte_valid  - byte_in is consumed this cycle
//   byte_in     - incoming byte
//   word_done   - the byte consumed this cycle completes a word
//   word_out    - the completed word (meaningful when word_done is 1)
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word_out
);

  // Only the three earlier bytes of a word need storing; the fourth is
  // taken straight from byte_in when the word completes.
  logic [23:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word_done = byte_valid && (cnt_q == 2'd3);
  assign word_out  = {sr_q, byte_in};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (byte_valid) begin
      sr_d  = {sr_q[15:0], byte_in};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a byte stream (16-bit big-endian word count N, N
// words MSB first, XOR checksum of the data bytes), writes the words into
// instruction memory at byte addresses 0, 4, 8, ... and then releases the
// CPU, or flags an error.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   in_valid     - loader byte present
//   in_data      - loader byte
//   in_ready     - byte accepted this cycle when in_valid is also 1
//   imem_we      - one-cycle instruction-memory write strobe
//   imem_addr    - word-aligned byte address of the write
//   imem_wdata   - instruction word to write
//   cpu_run      - CPU may fetch and execute (sticky until reset)
//   err          - load failed (sticky until reset)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [HDR_W-1:0]  count_q, count_d;
  logic [CSUM_W-1:0] csum_q,  csum_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              we_q,    we_d;
  logic [31:0]       addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              run_q,   run_d;
  logic              err_q,   err_d;

  logic        accept;
  logic        pk_valid;
  logic        pk_done;
  logic [31:0] pk_word;
  logic        last_word;

  // Ready is a decode of the state, forced low while reset is held.
  assign in_ready = !rst && (state_q inside {HDR_HI, HDR_LO, DATA, CSUM});
  assign accept   = in_valid && in_ready;
  assign pk_valid = accept && (state_q == DATA);

  // The word being completed is the last one when its index is N-1.
  assign last_word = (HDR_W'(idx_q) == (count_q - HDR_W'(1)));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (pk_valid),
    .byte_in    (in_data),
    .word_done  (pk_done),
    .word_out   (pk_word)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // Both flags follow their terminal state by one cycle and then stick.
    run_d   = run_q || (state_q == RUN);
    err_d   = err_q || (state_q == ERROR);

    unique case (state_q)
      HDR_HI: begin
        if (accept) begin
          count_d = {in_data, 8'h00};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = {count_q[HDR_W-1:8], in_data};
          state_d = count_ok(count_d, DEPTH) ? DATA : ERROR;
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (pk_done) begin
            we_d    = 1'b1;
            addr_d  = 32'({idx_q, 2'b00});
            wdata_d = pk_word;
            // Hold the index on the last word rather than letting it wrap.
            if (last_word) state_d = CSUM;
            else           idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? RUN : ERROR;
      end
      default: ;
    endcase
  end

  // NOTE: the instruction memory itself is outside this block; reset clears
  // only the loader's own state, so a previously loaded image survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HDR_HI;
      count_q <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = run_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed cycle-exact sequences plus a
// table of randomized streams scored against a stream-level reference model.
module tb_imem_loader;

  localparam int DEPTH = 256;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    string name;
    int    n;
    bit    bad_csum;
    int    min_gap;
    int    max_gap;
    bit    exp_run;
    bit    exp_err;
    int    exp_writes;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Writes seen on the memory port, and writes the model expects.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_run;
  bit          exp_err;

  int          excl_viol = 0;
  int          hold_viol = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .err        (err)
  );

  // Port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      if (cpu_run && err) excl_viol++;
      if (imem_we) begin
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_wdata);
        last_addr = imem_addr;
        last_data = imem_wdata;
      end else if (imem_addr !== last_addr || imem_wdata !== last_data) begin
        hold_viol++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: parse a whole offered stream by the format rules.
  function automatic void model(input byte_q_t s);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_run = 1'b0;
    exp_err = 1'b0;
    if (s.size() < 2) return;
    n = s[0] * 256 + s[1];
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    if (s.size() < 2 + 4 * n + 1) return;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
      exp_addr.push_back(32'(4 * i));
      exp_data.push_back(w);
      x = x ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
    end
    exp_run = (s[2+4*n] == x);
    exp_err = !exp_run;
  endfunction

  // Header, random words, checksum (optionally corrupted), trailing junk.
  function automatic byte_q_t make_stream(input int n, input bit bad);
    byte_q_t     s;
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        for (int b = 3; b >= 0; b--) begin
          s.push_back(w[8*b +: 8]);
          x = x ^ w[8*b +: 8];
        end
      end
      s.push_back(bad ? (x ^ 8'hA5) : x);
    end
    for (int i = 0; i < 3; i++) s.push_back(8'($urandom));
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst imem_we", 32'(imem_we), 0);
    check("rst imem_addr", imem_addr, 0);
    check("rst imem_wdata", imem_wdata, 0);
    check("rst cpu_run", 32'(cpu_run), 0);
    check("rst err", 32'(err), 0);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic run_stream(input byte_q_t s, input int min_gap, input int max_gap,
                            input string name, input bit with_reset);
    model(s);
    if (with_reset) do_reset();
    wr_addr.delete();
    wr_data.delete();
    excl_viol = 0;
    hold_viol = 0;
    foreach (s[i]) send_byte(s[i], int'($urandom_range(max_gap, min_gap)));
    idle(6);
    check({name, " write count"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", name, i), wr_addr[i], exp_addr[i]);
      check($sformatf("%s data[%0d]", name, i), wr_data[i], exp_data[i]);
    end
    check({name, " cpu_run"}, 32'(cpu_run), 32'(exp_run));
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " in_ready after load"}, 32'(in_ready), 0);
    check({name, " run/err exclusive"}, 32'(excl_viol), 0);
    check({name, " addr/data hold"}, 32'(hold_viol), 0);
  endtask

  initial begin
    vec_t    vecs[9];
    byte_q_t s;

    vecs[0] = '{"n0",      0,   1'b0, 0, 2, 1'b0, 1'b1, 0};
    vecs[1] = '{"n257",    257, 1'b0, 0, 2, 1'b0, 1'b1, 0};
    vecs[2] = '{"n0101",   257, 1'b0, 0, 0, 1'b0, 1'b1, 0};
    vecs[3] = '{"n1 ok",   1,   1'b0, 0, 3, 1'b1, 1'b0, 1};
    vecs[4] = '{"n1 bad",  1,   1'b1, 0, 3, 1'b0, 1'b1, 1};
    vecs[5] = '{"n5 gaps", 5,   1'b0, 1, 4, 1'b1, 1'b0, 5};
    vecs[6] = '{"n2 bad",  2,   1'b1, 0, 2, 1'b0, 1'b1, 2};
    vecs[7] = '{"n256",    256, 1'b0, 0, 0, 1'b1, 1'b0, 256};
    vecs[8] = '{"n17",     17,  1'b0, 0, 1, 1'b1, 1'b0, 17};

    // Single-word stream, cycle-exact: write pulse coincides with the
    // checksum byte's acceptance, cpu_run follows RUN by one cycle.
    do_reset();
    wr_addr.delete();
    wr_data.delete();
    s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    for (int i = 0; i < 6; i++) send_byte(s[i], 0);
    @(negedge clk);
    check("d34 we pulse", 32'(imem_we), 1);
    check("d34 addr", imem_addr, 32'h0);
    check("d34 wdata", imem_wdata, 32'h20080005);
    check("d34 ready in csum", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data = 8'h2D;
    @(negedge clk);
    check("d34 we single", 32'(imem_we), 0);
    check("d34 ready in run", 32'(in_ready), 0);
    check("d34 run delayed", 32'(cpu_run), 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("d34 cpu_run", 32'(cpu_run), 1);
    check("d34 err", 32'(err), 0);
    check("d34 hold addr", imem_addr, 32'h0);
    check("d34 hold wdata", imem_wdata, 32'h20080005);

    // Zero-length header, cycle-exact error flag.
    do_reset();
    wr_addr.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("d36 ready in error", 32'(in_ready), 0);
    check("d36 err delayed", 32'(err), 0);
    @(negedge clk);
    check("d36 err", 32'(err), 1);
    check("d36 cpu_run", 32'(cpu_run), 0);
    idle(2);
    check("d36 no writes", 32'(wr_addr.size()), 0);

    // Three fixed words with in_valid toggling every other cycle.
    s = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
          8'h33, 8'h33, 8'h33, 8'h33, 8'h00};
    run_stream(s, 1, 1, "d35", 1'b1);

    // Good header and data, wrong checksum.
    s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hFF};
    run_stream(s, 0, 0, "d38", 1'b1);
    if (wr_data.size() > 0) check("d38 word0", wr_data[0], 32'h20080005);

    // Reset raised between edges after two data bytes, then a clean load.
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(s[i], 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("d39 async in_ready", 32'(in_ready), 0);
    check("d39 async imem_we", 32'(imem_we), 0);
    check("d39 async addr", imem_addr, 0);
    check("d39 async wdata", imem_wdata, 0);
    check("d39 async cpu_run", 32'(cpu_run), 0);
    check("d39 async err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    run_stream(s, 0, 2, "d39 reload", 1'b0);

    // Randomized table.
    foreach (vecs[i]) begin
      s = make_stream(vecs[i].n, vecs[i].bad_csum);
      if (vecs[i].name == "n0101") begin
        s[0] = 8'h01;
        s[1] = 8'h01;
      end
      run_stream(s, vecs[i].min_gap, vecs[i].max_gap, vecs[i].name, 1'b1);
      check({vecs[i].name, " table run"}, 32'(cpu_run), 32'(vecs[i].exp_run));
      check({vecs[i].name, " table err"}, 32'(err), 32'(vecs[i].exp_err));
      check({vecs[i].name, " table writes"}, 32'(wr_addr.size()), 32'(vecs[i].exp_writes));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the loader byte is present.
REQ-005 SHALL have port in_data, input, 8 bits: the loader byte.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-007 SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-008 SHALL have port imem_addr, output, 32 bits: byte address, word-aligned, equal to the PC value that fetches the word.
REQ-009 SHALL have port imem_wdata, output, 32 bits: instruction word.
REQ-010 SHALL have port cpu_run, output, 1 bit: the CPU may fetch and execute; low holds the CPU.
REQ-011 SHALL have port err, output, 1 bit: the load failed; sticky until reset.

Function
REQ-012 A byte SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-013 The stream format SHALL be: count N (16 bits, big-endian, 2 bytes), then N words of 4 bytes each, MSB first, then 1 checksum byte.
REQ-014 The state machine SHALL have the states HDR_HI, HDR_LO, DATA, CSUM, RUN, ERROR.
REQ-015 Transitions: HDR_HI->HDR_LO on accept; HDR_LO->DATA on accept if 1<=N<=DEPTH, otherwise ->ERROR.
REQ-016 DATA->CSUM SHALL occur on acceptance of byte 4N.
REQ-017 CSUM->RUN SHALL occur if the accepted byte equals the XOR of all 4N data bytes, otherwise ->ERROR; header bytes are excluded from the checksum.
REQ-018 in_ready SHALL be 1 in HDR_HI, HDR_LO, DATA and CSUM, and 0 in RUN and ERROR; no backpressure is applied during a load.
REQ-019 The block SHALL pulse imem_we for exactly one cycle, the cycle after accepting byte 4k+4 (k = 0..N-1), with imem_addr = 4k and imem_wdata = the assembled word.
REQ-020 When imem_we is 0, imem_addr and imem_wdata SHALL hold their last values.
REQ-021 The last word's imem_we SHALL coincide with the first CSUM cycle; a checksum byte accepted that same cycle SHALL be legal.
REQ-022 cpu_run SHALL rise the cycle after entering RUN and stay 1 until reset.
REQ-023 err SHALL rise the cycle after entering ERROR and stay 1 until reset.
REQ-024 cpu_run and err SHALL never both be 1.
REQ-025 in_valid gaps of any length SHALL be tolerated in every loading state with no state change.
REQ-026 Bytes offered in RUN or ERROR SHALL be ignored.
REQ-027 The word index SHALL be ceil(log2(DEPTH)) bits and SHALL not wrap, because N<=DEPTH is enforced.

Reset
REQ-028 rst=1 SHALL asynchronously force state HDR_HI, with in_ready=0 while rst is high, and imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, err=0.
REQ-029 The checksum accumulator, byte counter and word index SHALL clear to 0 on reset.
REQ-030 Reset mid-load SHALL abandon the load; a new stream SHALL start with HDR_HI on the first accepted byte after rst falls.
REQ-031 Instruction-memory contents SHALL not be altered by reset.

Structure
REQ-032 The state enum, the DEPTH default, and the header and checksum widths SHALL live in shared package imem_loader_pkg.
REQ-033 Byte-to-word packing (a 4-byte shift register plus a 2-bit byte counter with a word-complete flag) SHALL be sub-module byte_packer; the FSM, checksum and address counter SHALL stay in imem_loader.

Verification
REQ-034 Stream 00 01 | 20 08 00 05 | 2D -> one imem_we with addr 0x0 and wdata 0x20080005, then cpu_run=1 and err=0.
REQ-035 N=3 words 0x11111111, 0x22222222, 0x33333333 with checksum 0x00, and in_valid toggling every other cycle -> writes at addresses 0x0, 0x4, 0x8 in order, then cpu_run=1.
REQ-036 Header 00 00 -> err=1 the cycle after ERROR is entered, with no imem_we and in_ready=0.
REQ-037 Header 01 01 with DEPTH=256 -> ERROR and err=1.
REQ-038 A valid single-word stream with checksum 0xFF instead of 0x2D -> imem_we for word 0 occurs, then err=1 and cpu_run=0.
REQ-039 rst asserted asynchronously after 2 data bytes, then a full valid stream -> all outputs 0 during rst, and the new stream loads to address 0x0 and reaches cpu_run=1.
